// File: rtl/set_bit_serializer.sv
// Purpose: splits an OR-merged request mask into one beat per set bit, lowest bit first.
// Latency: first beat in the cycle after the word is accepted, then one beat per cycle.
// Backpressure: out_ready low holds every output stable; in_ready is high only when idle.
// Optional: SET_BIT_SERIALIZER_EMPTY_BEAT_EN turns a zero mask into a single empty beat.
module set_bit_serializer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_last,
  output logic [IDX_W:0]   out_seq,
  output logic             busy
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
  ,
  output logic             out_empty
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [IDX_W:0]   SEQ_ONE = (IDX_W+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W:0]   seq_q, seq_d;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
  logic             empty_q, empty_d;
`endif

  logic             emit;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] rest;
  logic [IDX_W-1:0] low_idx;

  // Isolate the lowest remaining set bit and encode its position.
  always_comb begin
    lowest  = rem_q & (~rem_q + ONE);
    rest    = rem_q & (rem_q - ONE);
    low_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Outputs come from registers only, forced to their idle values outside EMIT.
  always_comb begin
    emit       = (state_q == ST_EMIT);
    in_ready   = !emit;
    busy       = emit;
    out_valid  = emit;
    out_index  = emit ? low_idx : '0;
    out_onehot = emit ? lowest : '0;
    out_last   = emit && (rest == '0);
    out_seq    = seq_q;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
    out_empty  = empty_q;
`endif
  end

  // Next-state: load a word from IDLE, retire one bit per accepted beat in EMIT.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
    empty_d = empty_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_mask != '0) begin
            rem_d   = in_mask;
            seq_d   = '0;
            state_d = ST_EMIT;
          end
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
          else begin
            // A zero word still gets one marker beat so the consumer sees it.
            rem_d   = '0;
            seq_d   = '0;
            empty_d = 1'b1;
            state_d = ST_EMIT;
          end
`endif
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          rem_d = rem_q & ~lowest;
          seq_d = seq_q + SEQ_ONE;
          if (out_last) begin
            seq_d   = '0;
            state_d = ST_IDLE;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
            empty_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any word in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
      empty_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
`ifdef SET_BIT_SERIALIZER_EMPTY_BEAT_EN
      empty_q <= empty_d;
`endif
    end
  end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
- Decomposes a 32-bit OR-merged request mask into its individual set bits, one per handshake beat.
- Emits each set bit as an index plus a one-hot word, lowest bit first.
- Sits between merged event/interrupt request sources and the CPU-side handler that services one source at a time.
- Multi-cycle: one input word yields popcount(mask) output beats.

Parameters:
- WIDTH, 32, mask width in bits.
- IDX_W, 5, index width; equals log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_mask is presented.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_mask  input  WIDTH  OR-merged request mask.
- out_valid  output  1  out_index, out_onehot, out_last and out_seq are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_index  output  IDX_W  bit position of the lowest remaining set bit.
- out_onehot  output  WIDTH  1 << out_index.
- out_last  output  1  current beat is the final beat of the word.
- out_seq  output  IDX_W+1  beat number within the current word, starting at 0.
- busy  output  1  high while in EMIT.

Behaviour:
- Reset (reset_n low, takes effect immediately):
  - State goes to IDLE; remaining-mask register and out_seq clear to 0.
  - Outputs: in_ready=1, out_valid=0, out_index=0, out_onehot=0, out_last=0, out_seq=0, busy=0.
  - A reset in the middle of EMIT abandons the word; no further beats are produced.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready with in_mask != 0: remaining <= in_mask, out_seq <= 0, go to EMIT.
  - On in_valid && in_ready with in_mask == 0: word is consumed and produces no beat; stay in IDLE (feature macro changes this).
- State EMIT:
  - Outputs: in_ready=0, busy=1, out_valid=1.
  - out_index = position of the lowest set bit of remaining.
  - out_onehot = remaining & (~remaining + 1).
  - out_last = (remaining & (remaining - 1)) == 0.
  - Outputs are combinational from registers only; no input-to-output combinational path except through the handshake.
  - On out_valid && out_ready:
    - remaining <= remaining & ~out_onehot.
    - out_seq <= out_seq + 1.
    - If out_last: go to IDLE and clear out_seq to 0.
  - Stall (out_ready=0): all outputs hold exactly stable; remaining does not change.
- Latency:
  - A word accepted on edge N gives its first beat with out_valid=1 in the cycle after edge N.
  - Each subsequent beat follows one cycle after the previous handshake.
  - Throughput is one beat per cycle while out_ready=1.
  - After the last handshake, in_ready is 1 in the next cycle, so there is one IDLE cycle between words.
- Boundaries:
  - in_mask all-ones gives 32 beats, indices 0..31, out_seq 0..31; out_last only on index 31.
  - out_seq width IDX_W+1 never wraps, maximum 31.
  - in_mask with only bit 31 set gives a single beat: index 31, onehot 0x80000000, out_last=1.
  - in_valid is ignored while busy; the upstream source must hold in_mask until in_ready is high.

Optional Feature:
- Macro: SET_BIT_SERIALIZER_EMPTY_BEAT_EN.
- With the macro defined:
  - An added output port out_empty (1 bit) exists.
  - An accepted zero mask produces exactly one beat: out_index=0, out_onehot=0, out_last=1, out_seq=0, out_empty=1.
  - out_empty is 0 on all other beats and during reset.
  - The block enters EMIT for that beat and returns to IDLE on its handshake.
- Without the macro:
  - No out_empty port.
  - A zero mask is consumed silently with no beat; in_ready stays 1.

Test Plan:
- Reset: reset_n low mid-word after 2 of 4 beats of mask 0x0000_00F0 -> out_valid=0, in_ready=1 immediately; after release, no beat until the next word.
- Basic decomposition: in_mask=0x8000_0005, out_ready=1 -> 3 beats:
  - index 0, onehot 0x1, seq 0, last 0;
  - index 2, onehot 0x4, seq 1, last 0;
  - index 31, onehot 0x8000_0000, seq 2, last 1;
  - then in_ready=1 on the following cycle.
- Backpressure: in_mask=0x0000_0300, out_ready low for 5 cycles -> index 8 and onehot 0x100 held stable for all 5 cycles; releasing out_ready gives index 9 with last=1; in_valid pulses during EMIT are ignored.
- Full mask: in_mask=0xFFFF_FFFF, out_ready=1 -> 32 consecutive beats, indices 0..31, seq equals index, last only on beat 31; busy high for exactly 32 cycles.
- Zero mask:
  - Without the macro: 0x0 -> no out_valid, in_ready stays 1.
  - With SET_BIT_SERIALIZER_EMPTY_BEAT_EN: one beat with out_empty=1, out_onehot=0, out_last=1.
- Back-to-back words: 0x0000_0001 then 0x0000_0002 presented with in_valid held -> index 0 (last), one IDLE cycle, then index 1 (last).
